// File: rtl/ram_march_bist.sv
`default_nettype none
// ============================================================================
// Module  : ram_march_bist
// Brief   : March C- BIST initiator for one port of a 1-cycle-latency RAM,
//           with error counting and first-failure capture.
//           Option macro BIST_CONTINUE_ON_FAIL_EN: when defined, every element
//           runs to completion; otherwise the first mismatch ends the test.
// Revision: 1.0 - initial release
// ============================================================================
module ram_march_bist #(
    parameter int                DATA_W  = 8,
    parameter int                ADDR_W  = 6,
    parameter logic [DATA_W-1:0] PATTERN = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_act,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_M0   = 3'd1;
    localparam logic [2:0] S_M1   = 3'd2;
    localparam logic [2:0] S_M2   = 3'd3;
    localparam logic [2:0] S_M3   = 3'd4;
    localparam logic [2:0] S_M4   = 3'd5;
    localparam logic [2:0] S_M5   = 3'd6;
    localparam logic [2:0] S_DONE = 3'd7;

    localparam logic [ADDR_W-1:0] c_ADDR_MAX = '1;
    localparam logic [DATA_W-1:0] c_D0       = PATTERN;
    localparam logic [DATA_W-1:0] c_D1       = ~PATTERN;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_ph;
    logic [7:0]        r_err_cnt;
    logic [ADDR_W-1:0] r_fail_addr;
    logic [DATA_W-1:0] r_fail_exp;
    logic [DATA_W-1:0] r_fail_act;
    logic              r_pass;

    logic              w_run;
    logic              w_rw;
    logic              w_down;
    logic              w_cmp;
    logic [DATA_W-1:0] w_exp;
    logic [DATA_W-1:0] w_wdata;
    logic              w_mis;
    logic              w_last;
    logic              w_step;
    logic              w_abort;
    logic              w_to_done;
    logic [7:0]        w_err_nxt;
    logic [2:0]        w_next_elem;
    logic [ADDR_W-1:0] w_next_start;

    assign w_run   = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_rw    = (r_state >= S_M1) && (r_state <= S_M4);
    assign w_down  = (r_state == S_M3) || (r_state == S_M4);
    // r_ph=1 is the second cycle of a two-cycle address slot; ram_q then holds the read.
    assign w_cmp   = (w_rw || (r_state == S_M5)) && r_ph;
    assign w_exp   = ((r_state == S_M2) || (r_state == S_M4)) ? c_D1 : c_D0;
    assign w_wdata = ((r_state == S_M1) || (r_state == S_M3)) ? c_D1 : c_D0;
    assign w_mis   = w_cmp && (ram_q != w_exp);
    assign w_last  = w_down ? (r_addr == '0) : (r_addr == c_ADDR_MAX);
    assign w_step  = (r_state == S_M0) || r_ph;

    assign w_err_nxt    = !w_mis ? r_err_cnt :
                          ((r_err_cnt == 8'hFF) ? 8'hFF : r_err_cnt + 8'd1);
    assign w_next_elem  = r_state + 3'd1;
    assign w_next_start = ((r_state == S_M2) || (r_state == S_M3)) ? c_ADDR_MAX : '0;

`ifdef BIST_CONTINUE_ON_FAIL_EN
    assign w_abort = 1'b0;
`else
    assign w_abort = w_mis;
`endif

    assign w_to_done = w_abort || ((r_state == S_M5) && w_step && w_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_ph        <= 1'b0;
            r_err_cnt   <= '0;
            r_fail_addr <= '0;
            r_fail_exp  <= '0;
            r_fail_act  <= '0;
            r_pass      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_M0;
                        r_addr      <= '0;
                        r_ph        <= 1'b0;
                        r_err_cnt   <= '0;
                        r_fail_addr <= '0;
                        r_fail_exp  <= '0;
                        r_fail_act  <= '0;
                        r_pass      <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    if (w_mis) begin
                        r_err_cnt <= w_err_nxt;
                        if (r_err_cnt == 8'd0) begin
                            r_fail_addr <= r_addr;
                            r_fail_exp  <= w_exp;
                            r_fail_act  <= ram_q;
                        end
                    end
                    if (w_to_done) begin
                        r_pass <= (w_err_nxt == 8'd0);
                    end
                    if (w_abort) begin
                        r_state <= S_DONE;
                        r_ph    <= 1'b0;
                    end else if (w_step) begin
                        r_ph <= 1'b0;
                        if (w_last) begin
                            r_state <= w_next_elem;
                            r_addr  <= w_next_start;
                        end else begin
                            r_addr <= w_down ? r_addr - 1'b1 : r_addr + 1'b1;
                        end
                    end else begin
                        r_ph <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign busy      = w_run;
    assign done      = (r_state == S_DONE);
    assign pass      = r_pass;
    assign err_cnt   = r_err_cnt;
    assign fail_addr = r_fail_addr;
    assign fail_exp  = r_fail_exp;
    assign fail_act  = r_fail_act;
    assign ram_addr  = w_run ? r_addr : '0;
    assign ram_data  = w_run ? w_wdata : '0;
    assign ram_we    = w_run && ((r_state == S_M0) || (w_rw && r_ph));

endmodule
`default_nettype wire

// File: tb/tb_ram_march_bist.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram_march_bist
// Brief   : Directed self-checking bench for ram_march_bist with behavioural
//           RAM models (optional stuck-at-1 fault at address 5 bit 3).
// Revision: 1.0 - initial release
// ============================================================================
module tb_ram_march_bist;

    logic       clk;
    logic       rst_n;
    logic       start;
    int         sel;
    logic       fault_en;
    int         n_cmp;
    int         n_bad;

    logic       busy0, done0, pass0, we0;
    logic [7:0] err0, fexp0, fact0, data0, q0;
    logic [5:0] faddr0, addr0;
    logic       busy1, done1, pass1, we1;
    logic [7:0] err1, fexp1, fact1, data1, q1;
    logic [5:0] faddr1, addr1;
    logic       start0, start1;

    logic [7:0] mem0 [64];
    logic [7:0] mem1 [64];

    assign start0 = start && (sel == 0);
    assign start1 = start && (sel == 1);

    ram_march_bist #(.DATA_W(8), .ADDR_W(6), .PATTERN(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
        .pass(pass0), .err_cnt(err0), .fail_addr(faddr0), .fail_exp(fexp0),
        .fail_act(fact0), .ram_addr(addr0), .ram_data(data0), .ram_we(we0),
        .ram_q(q0)
    );

    ram_march_bist #(.DATA_W(8), .ADDR_W(6), .PATTERN(8'hA5)) dut_a5 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .pass(pass1), .err_cnt(err1), .fail_addr(faddr1), .fail_exp(fexp1),
        .fail_act(fact1), .ram_addr(addr1), .ram_data(data1), .ram_we(we1),
        .ram_q(q1)
    );

    // Synchronous RAMs: write when we=1, otherwise q registers the addressed word.
    always @(posedge clk) begin
        if (we0) mem0[addr0] <= data0;
        else     q0 <= mem0[addr0] | ((fault_en && addr0 == 6'd5) ? 8'h08 : 8'h00);
        if (we1) mem1[addr1] <= data1;
        else     q1 <= mem1[addr1];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire       b_busy = (sel == 1) ? busy1 : busy0;
    wire       b_done = (sel == 1) ? done1 : done0;
    wire       b_pass = (sel == 1) ? pass1 : pass0;
    wire       b_we   = (sel == 1) ? we1   : we0;
    wire [5:0] b_addr = (sel == 1) ? addr1 : addr0;
    wire [7:0] b_data = (sel == 1) ? data1 : data0;
    wire [7:0] b_err  = (sel == 1) ? err1  : err0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start a run and trace every busy cycle against the March C- port schedule.
    task automatic do_run(input int pulse_at, input bit hold,
                          output int lat, output int ncyc, output int bad, output bit dn);
        logic [7:0] p;
        logic       ewe;
        logic [5:0] ea;
        logic [7:0] ed;
        int         j, e, i, ph;
        p     = (sel == 1) ? 8'hA5 : 8'h00;
        start = 1'b1;
        lat   = 0;
        ncyc  = 0;
        bad   = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!b_busy && lat < 8);
        if (!hold) start = 1'b0;
        while (b_busy && ncyc < 2000) begin
            if (ncyc < 64) begin
                ewe = 1'b1;
                ea  = 6'(ncyc);
                ed  = p;
            end else begin
                j   = ncyc - 64;
                e   = j / 128;
                i   = (j % 128) / 2;
                ph  = j % 2;
                ea  = (e == 2 || e == 3) ? 6'(63 - i) : 6'(i);
                ewe = (e < 4) && (ph == 1);
                ed  = (e == 0 || e == 2) ? ~p : p;
            end
            if (b_we !== ewe || b_addr !== ea || (ewe && b_data !== ed)) bad++;
            ncyc++;
            if (!hold) start = (ncyc == pulse_at);
            @(negedge clk);
        end
        if (!hold) start = 1'b0;
        dn = b_done;
    endtask

    initial begin
        int lat, ncyc, bad;
        bit dn;
        n_cmp    = 0;
        n_bad    = 0;
        sel      = 0;
        fault_en = 1'b0;
        start    = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_busy", busy0, 1'b0);
        check("rst_done", done0, 1'b0);
        check("rst_pass", pass0, 1'b0);
        check("rst_err", err0, 8'h00);
        check("rst_faddr", faddr0, 6'd0);
        check("rst_we", we0, 1'b0);
        check("rst_addr", addr0, 6'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fault-free run
        do_run(-1, 1'b0, lat, ncyc, bad, dn);
        check("t1_lat", lat, 1);
        check("t1_cycles", ncyc, 704);
        check("t1_trace", bad, 0);
        check("t1_done", dn, 1'b1);
        check("t1_pass", pass0, 1'b1);
        check("t1_err", err0, 8'h00);
        check("t1_we_idle", we0, 1'b0);
        @(negedge clk);
        check("t1_done_pulse", done0, 1'b0);
        check("t1_pass_hold", pass0, 1'b1);

        // Stuck-at-1 on bit 3 of address 5
        fault_en = 1'b1;
        do_run(-1, 1'b0, lat, ncyc, bad, dn);
        check("t2_trace", bad, 0);
        check("t2_done", dn, 1'b1);
        check("t2_pass", pass0, 1'b0);
        check("t2_faddr", faddr0, 6'd5);
        check("t2_fexp", fexp0, 8'h00);
        check("t2_fact", fact0, 8'h08);
`ifdef BIST_CONTINUE_ON_FAIL_EN
        check("t3_cycles", ncyc, 704);
        check("t3_err", err0, 8'd3);
`else
        check("t2_cycles", ncyc, 76);
        check("t2_err", err0, 8'd1);
`endif
        fault_en = 1'b0;
        @(negedge clk);

        // Reset mid-run
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (299) @(negedge clk);
        check("t4_busy_pre", busy0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t4_busy", busy0, 1'b0);
        check("t4_we", we0, 1'b0);
        check("t4_addr", addr0, 6'd0);
        check("t4_data", data0, 8'h00);
        check("t4_err", err0, 8'h00);
        check("t4_pass", pass0, 1'b0);
        check("t4_faddr", faddr0, 6'd0);
        @(negedge clk);
        @(negedge clk);
        check("t4_no_done", done0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        do_run(-1, 1'b0, lat, ncyc, bad, dn);
        check("t4_cycles", ncyc, 704);
        check("t4_pass2", pass0, 1'b1);

        // start pulsed mid-run is ignored
        @(negedge clk);
        do_run(100, 1'b0, lat, ncyc, bad, dn);
        check("t5_cycles", ncyc, 704);
        check("t5_trace", bad, 0);
        check("t5_done", dn, 1'b1);
        @(negedge clk);
        check("t5_idle", busy0, 1'b0);

        // start held high: back-to-back runs
        do_run(-1, 1'b1, lat, ncyc, bad, dn);
        check("t5b_cycles1", ncyc, 704);
        check("t5b_done1", dn, 1'b1);
        do_run(-1, 1'b1, lat, ncyc, bad, dn);
        check("t5b_lat2", lat, 2);
        check("t5b_cycles2", ncyc, 704);
        check("t5b_done2", dn, 1'b1);
        check("t5b_pass2", pass0, 1'b1);
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Alternate background pattern
        sel = 1;
        do_run(-1, 1'b0, lat, ncyc, bad, dn);
        check("t6_cycles", ncyc, 704);
        check("t6_trace", bad, 0);
        check("t6_done", dn, 1'b1);
        check("t6_pass", b_pass, 1'b1);
        check("t6_err", b_err, 8'h00);
        check("t6_mem0", mem1[0], 8'hA5);
        check("t6_mem63", mem1[63], 8'hA5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
